burst_rr_arbiter: RTL

//  Shares one downstream valid/ready stream port between NUM_REQ upstream requesters.

---
 rtl/burst_rr_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/burst_rr_arbiter.sv
// rtl/burst_rr_arbiter.sv - round-robin arbiter holding each grant for a whole valid/ready burst
module burst_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_last_o,
    output logic [$clog2(NUM_REQ)-1:0] out_id_o,
    input  logic                       out_ready_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       burst_err_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BEATS + 2);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] mask, mask_nxt, masked, pick;
    logic [ID_W-1:0]    win_id;
    logic [CNT_W-1:0]   beat_cnt;
    logic               xfer;

    assign xfer = (state == BUSY) && req_valid_i[out_id_o] && out_ready_i;

    always_comb begin
        state_nxt   = state;
        out_valid_o = 1'b0;
        req_ready_o = '0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == out_id_o) begin
                out_data_o = req_data_i[k*DATA_W +: DATA_W];
                out_last_o = req_last_i[k];
            end
        end
        case (state)
            IDLE: begin
                if (|req_valid_i) state_nxt = BUSY;
            end
            BUSY: begin
                out_valid_o           = req_valid_i[out_id_o];
                req_ready_o[out_id_o] = out_ready_i;
                if (xfer && out_last_o) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Masked requests take priority so the port after the last-served one wins.
    always_comb begin
        masked = req_valid_i & mask;
        pick   = (masked != '0) ? masked : req_valid_i;
        win_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick[i]) win_id = ID_W'(i);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_nxt[i] = (i > int'(out_id_o));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gnt_o       <= '0;
            out_id_o    <= '0;
            mask        <= '1;
            beat_cnt    <= '0;
            burst_err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (|req_valid_i)) begin
                gnt_o    <= NUM_REQ'(1) << win_id;
                out_id_o <= win_id;
                beat_cnt <= '0;
            end
            if (xfer) begin
                // A non-last beat at position MAX_BEATS proves the burst is too long.
                if (!out_last_o && beat_cnt >= CNT_LAST) burst_err_o <= 1'b1;
                if (out_last_o) begin
                    gnt_o    <= '0;
                    beat_cnt <= '0;
                    mask     <= mask_nxt;
                end else if (beat_cnt != CNT_SAT) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule
